// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit path: byte width and feeder FSM states.
package uart_tx_feeder_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitAck  = 2'd1,
    StWaitDone = 2'd2,
    StWaitIdle = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level; storage is not reset.
module uart_sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LvlW'(Depth));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them to the 8N1 serializer one shift pulse at a time,
// pacing on the serializer's busy flag.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 4,
  localparam int unsigned LvlW = $clog2(DEPTH) + 1,
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT)
) (
  input  logic             ser_ck,
  input  logic             ser_rst_n,
  input  logic             wr_en,
  input  logic [ByteW-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [LvlW-1:0]  level,
  output logic             overflow,
  output logic             ack_err,
  input  logic             err_clr,
  output logic             shift,
  output logic [ByteW-1:0] shift_data,
  input  logic             ser_busy,
  output logic             tx_active
);

  feeder_state_e    state_q;
  logic [CntW-1:0]  cnt_q;
  logic             shift_q, overflow_q, ack_err_q;
  logic [ByteW-1:0] shift_data_q, fifo_rdata;
  logic             pop, ack_timeout;

  uart_sync_fifo #(
    .Depth (DEPTH),
    .Width (ByteW)
  ) u_fifo (
    .clk_i   (ser_ck),
    .rst_ni  (ser_rst_n),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign pop         = (state_q == StIdle) && !empty && !ser_busy;
  assign ack_timeout = (state_q == StWaitAck) && !ser_busy &&
                       (cnt_q == CntW'(ACK_TIMEOUT - 1));

  // Out of reset we wait for busy low: the serializer may still be mid-frame.
  always_ff @(posedge ser_ck) begin
    if (!ser_rst_n) begin
      state_q      <= StWaitIdle;
      cnt_q        <= '0;
      shift_q      <= 1'b0;
      shift_data_q <= '0;
    end else begin
      shift_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            shift_q      <= 1'b1;
            shift_data_q <= fifo_rdata;
            cnt_q        <= '0;
            state_q      <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (ser_busy)         state_q <= StWaitDone;
          else if (ack_timeout) state_q <= StIdle;
          else                  cnt_q   <= cnt_q + 1'b1;
        end
        StWaitDone, StWaitIdle: begin
          if (!ser_busy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Error sets take priority over a same-cycle clear.
  always_ff @(posedge ser_ck) begin
    if (!ser_rst_n) begin
      overflow_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow_q <= 1'b0;
        ack_err_q  <= 1'b0;
      end
      if (wr_en && full) overflow_q <= 1'b1;
      if (ack_timeout)   ack_err_q  <= 1'b1;
    end
  end

  assign shift      = shift_q;
  assign shift_data = shift_data_q;
  assign overflow   = overflow_q;
  assign ack_err    = ack_err_q;
  assign tx_active  = (level != '0) || (state_q != StIdle) || ser_busy;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: serializer model plus a queue-based reference of the FIFO/flags.
module tb_uart_tx_feeder;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned ACK_TIMEOUT = 4;
  localparam int unsigned LvlW        = $clog2(DEPTH) + 1;

  logic            ser_ck = 1'b0, ser_rst_n = 1'b0, wr_en = 1'b0, err_clr = 1'b0;
  logic            ser_busy = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            full, empty, overflow, ack_err, shift, tx_active;
  logic [LvlW-1:0] level;
  logic [7:0]      shift_data;

  uart_tx_feeder #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .ser_ck     (ser_ck),
    .ser_rst_n  (ser_rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .ack_err    (ack_err),
    .err_clr    (err_clr),
    .shift      (shift),
    .shift_data (shift_data),
    .ser_busy   (ser_busy),
    .tx_active  (tx_active)
  );

  always #5 ser_ck = ~ser_ck;

  int total = 0, bad = 0, cyc = 0;
  logic [7:0] q[$];
  logic [7:0] shift_log[$];
  bit  ovf_exp, ack_exp, ack_on, shift_prev, force_busy, noack, gap_chk, fall_valid;
  int  ack_n, busy_left, frame_len = 10, shift_count, fall_cyc;
  logic [7:0] last_data = 8'h00, last_shift_byte;
  logic sb;
  bit   fb, ovf_set, ack_set;
  logic [7:0] e;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model and serializer model, evaluated just after each active edge.
  always begin
    @(posedge ser_ck);
    #1;
    cyc++;
    sb = ser_busy;
    ovf_set = 0;
    ack_set = 0;
    if (!ser_rst_n) begin
      q.delete();
      ovf_exp = 0; ack_exp = 0; ack_on = 0; last_data = 8'h00;
      check(shift == 1'b0, "rst_shift", int'(shift), 0);
      check(shift_data == 8'h00, "rst_shift_data", int'(shift_data), 0);
    end else begin
      if (ack_on) begin
        if (sb) ack_on = 0;
        else begin
          ack_n++;
          if (ack_n == ACK_TIMEOUT) begin ack_set = 1; ack_on = 0; end
        end
      end
      fb = (q.size() == DEPTH);
      if (shift) begin
        check(!sb, "shift_while_busy", int'(sb), 0);
        check(!shift_prev, "shift_width", 2, 1);
        if (gap_chk && fall_valid) begin
          check(cyc - fall_cyc == 2, "shift_gap", cyc - fall_cyc, 2);
          fall_valid = 0;
        end
        if (q.size() == 0) check(0, "shift_from_empty", 1, 0);
        else begin
          e = q.pop_front();
          check(shift_data == e, "shift_data", int'(shift_data), int'(e));
          last_data = e;
        end
        last_shift_byte = shift_data;
        shift_log.push_back(shift_data);
        shift_count++;
        ack_on = 1;
        ack_n  = 0;
      end else begin
        check(shift_data == last_data, "data_hold", int'(shift_data), int'(last_data));
      end
      if (wr_en) begin
        if (fb) ovf_set = 1;
        else q.push_back(wr_data);
      end
      if (err_clr) begin ovf_exp = 0; ack_exp = 0; end
      if (ovf_set) ovf_exp = 1;
      if (ack_set) ack_exp = 1;
    end
    check(int'(level) == q.size(), "level", int'(level), q.size());
    check(full == (q.size() == DEPTH), "full", int'(full), int'(q.size() == DEPTH));
    check(empty == (q.size() == 0), "empty", int'(empty), int'(q.size() == 0));
    check(overflow == ovf_exp, "overflow", int'(overflow), int'(ovf_exp));
    check(ack_err == ack_exp, "ack_err", int'(ack_err), int'(ack_exp));
    // Serializer: latches shift at this edge, busy visible from the next one.
    if (busy_left > 0) busy_left--;
    if (shift_prev && !noack) busy_left = frame_len;
    ser_busy = force_busy || (busy_left > 0);
    if (sb && !ser_busy) begin fall_cyc = cyc; fall_valid = 1; end
    shift_prev = shift;
  end

  task automatic tick();
    @(posedge ser_ck);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge ser_ck);
    wr_en = 1'b1; wr_data = d;
    @(negedge ser_ck);
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge ser_ck);
    err_clr = 1'b1;
    @(negedge ser_ck);
    err_clr = 1'b0;
  endtask

  task automatic wait_shifts(input int target, input int budget);
    int k = 0;
    while (shift_count < target && k < budget) begin tick(); k++; end
    check(shift_count >= target, "shift_wait", shift_count, target);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(q.size() == 0 && busy_left == 0 && !ser_busy && !ack_on) && k < budget) begin
      tick(); k++;
    end
    check(k < budget, "idle_wait", k, budget);
    repeat (3) tick();
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] data;
    int         lvl;
    bit         full;
    bit         ovf;
  } vec_t;
  vec_t tbl[18];

  initial begin
    int c0, n, g;
    for (int i = 0; i < 16; i++) begin
      tbl[i].wr = 1; tbl[i].data = 8'h80 + 8'(i); tbl[i].lvl = i + 1;
      tbl[i].full = (i == 15); tbl[i].ovf = 0;
    end
    tbl[16].wr = 1; tbl[16].data = 8'hEE; tbl[16].lvl = 16; tbl[16].full = 1; tbl[16].ovf = 1;
    tbl[17].wr = 0; tbl[17].data = 8'h00; tbl[17].lvl = 16; tbl[17].full = 1; tbl[17].ovf = 1;

    // Reset values
    repeat (2) tick();
    check(int'(level) == 0, "rst_level", int'(level), 0);
    check(empty == 1'b1, "rst_empty", int'(empty), 1);
    check(full == 1'b0, "rst_full", int'(full), 0);
    check(overflow == 1'b0 && ack_err == 1'b0, "rst_flags", int'(overflow | ack_err), 0);
    check(tx_active == 1'b1, "rst_tx_active_wait_idle", int'(tx_active), 1);
    @(negedge ser_ck);
    ser_rst_n = 1'b1;
    repeat (2) tick();

    // Single byte, latency and tx_active
    c0 = shift_count;
    @(negedge ser_ck);
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    check(shift == 1'b0, "t1_no_early_shift", int'(shift), 0);
    @(negedge ser_ck);
    wr_en = 1'b0;
    tick();
    check(shift == 1'b1, "t1_latency", int'(shift), 1);
    tick();
    check(ser_busy && tx_active, "t1_tx_active_busy", int'(tx_active), 1);
    wait_idle(100);
    check(shift_count == c0 + 1, "t1_count", shift_count - c0, 1);
    check(last_shift_byte == 8'hA5, "t1_byte", int'(last_shift_byte), 'hA5);
    check(tx_active == 1'b0, "t1_tx_active_idle", int'(tx_active), 0);

    // Four back-to-back frames with gap checking
    gap_chk = 1; fall_valid = 0; c0 = shift_count;
    for (int i = 1; i <= 4; i++) begin
      @(negedge ser_ck);
      wr_en = 1'b1; wr_data = 8'(i);
    end
    @(negedge ser_ck);
    wr_en = 1'b0;
    wait_shifts(c0 + 4, 300);
    wait_idle(200);
    gap_chk = 0;
    for (int i = 0; i < 4; i++)
      check(shift_log[c0+i] == 8'(i + 1), "t2_order", int'(shift_log[c0+i]), i + 1);

    // Fill to full with busy held, overflow, drain, clear
    @(negedge ser_ck);
    force_busy = 1;
    repeat (2) tick();
    for (int i = 0; i < 18; i++) begin
      @(negedge ser_ck);
      wr_en = tbl[i].wr; wr_data = tbl[i].data;
      tick();
      check(int'(level) == tbl[i].lvl, $sformatf("t3_level[%0d]", i), int'(level), tbl[i].lvl);
      check(full == tbl[i].full, $sformatf("t3_full[%0d]", i), int'(full), int'(tbl[i].full));
      check(overflow == tbl[i].ovf, $sformatf("t3_ovf[%0d]", i), int'(overflow),
            int'(tbl[i].ovf));
    end
    c0 = shift_count;
    @(negedge ser_ck);
    wr_en = 1'b0; force_busy = 0;
    wait_shifts(c0 + 16, 600);
    check(last_shift_byte == 8'h8F, "t3_last_byte", int'(last_shift_byte), 'h8F);
    wait_idle(200);
    check(overflow == 1'b1, "t3_ovf_sticky", int'(overflow), 1);
    pulse_clr();
    tick();
    check(overflow == 1'b0, "t3_ovf_clr", int'(overflow), 0);

    // Serializer never acknowledges
    noack = 1; c0 = shift_count;
    push(8'h3C);
    wait_shifts(c0 + 1, 20);
    for (int i = 0; i < 3; i++) begin
      tick();
      check(ack_err == 1'b0, "t4_ack_early", int'(ack_err), 0);
    end
    tick();
    check(ack_err == 1'b1, "t4_ack_set", int'(ack_err), 1);
    check(tx_active == 1'b0, "t4_back_idle", int'(tx_active), 0);
    noack = 0; c0 = shift_count;
    push(8'h55);
    wait_shifts(c0 + 1, 20);
    check(last_shift_byte == 8'h55, "t4_next_byte", int'(last_shift_byte), 'h55);
    wait_idle(100);
    check(ack_err == 1'b1, "t4_ack_sticky", int'(ack_err), 1);
    pulse_clr();
    tick();
    check(ack_err == 1'b0, "t4_ack_clr", int'(ack_err), 0);

    // Reset with busy held and bytes pending
    @(negedge ser_ck);
    force_busy = 1;
    repeat (2) tick();
    push(8'hAA);
    push(8'hBB);
    @(negedge ser_ck);
    ser_rst_n = 1'b0;
    @(negedge ser_ck);
    ser_rst_n = 1'b1;
    c0 = shift_count;
    push(8'h11); push(8'h22); push(8'h33);
    repeat (6) tick();
    check(shift_count == c0, "t5_no_shift_busy", shift_count - c0, 0);
    gap_chk = 1; fall_valid = 0;
    @(negedge ser_ck);
    force_busy = 0;
    wait_shifts(c0 + 1, 30);
    check(last_shift_byte == 8'h11, "t5_first_byte", int'(last_shift_byte), 'h11);
    wait_idle(200);
    gap_chk = 0;
    check(shift_count == c0 + 3, "t5_count", shift_count - c0, 3);

    // Simultaneous push/pop at level 5, then stream 40 bytes across pointer wrap
    frame_len = 2;
    c0 = shift_count;
    @(negedge ser_ck);
    force_busy = 1;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge ser_ck);
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
    end
    @(negedge ser_ck);
    wr_en = 1'b0; force_busy = 0;
    @(negedge ser_ck);
    wr_en = 1'b1; wr_data = 8'hC5;
    tick();
    check(shift == 1'b1, "t6_pop", int'(shift), 1);
    check(int'(level) == 5, "t6_level_hold", int'(level), 5);
    n = 6; g = 0;
    while (n < 40 && g < 2000) begin
      @(negedge ser_ck);
      g++;
      if (q.size() < 12) begin wr_en = 1'b1; wr_data = 8'(n); n++; end
      else wr_en = 1'b0;
    end
    @(negedge ser_ck);
    wr_en = 1'b0;
    wait_idle(1000);
    check(shift_count == c0 + 40, "t6_count", shift_count - c0, 40);
    for (int j = 0; j < 40; j++)
      check(shift_log[c0+j] == ((j < 6) ? 8'hC0 + 8'(j) : 8'(j)), "t6_order",
            int'(shift_log[c0+j]), (j < 6) ? 'hC0 + j : j);

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      @(negedge ser_ck);
      wr_en     = ((i / 150) % 2 == 1) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      wr_data   = 8'($urandom);
      err_clr   = ($urandom_range(15) == 0);
      noack     = ($urandom_range(7) == 0);
      frame_len = $urandom_range(5, 1);
      ser_rst_n = ($urandom_range(299) != 0);
    end
    @(negedge ser_ck);
    wr_en = 1'b0; err_clr = 1'b0; noack = 0; ser_rst_n = 1'b1;
    wait_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    check(0, "watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
